alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 select  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 zero, carry, sign, parity, overflow  output  1 each  result flags.
REQ-013 op_count  output  16  completed-result count; present only per REQ-032.

Function
REQ-014 Input handshake SHALL complete on a cycle with in_valid && in_ready; output handshake on out_valid && out_ready.
REQ-015 Two register stages SHALL exist: S1 holds the accepted a/b/select; S2 holds the computed out and flags.
REQ-016 Latency SHALL be 2 cycles: operands accepted at edge N appear with out_valid=1 after edge N+2, absent stall.
REQ-017 S2 SHALL load from S1 when S1 is valid and (S2 empty or out_ready=1); S1 SHALL load when in_valid && in_ready.
REQ-018 in_ready SHALL equal !S1_valid || (S2 empty or out_ready), combinationally; sustained throughput one result per cycle.
REQ-019 While out_valid=1 and out_ready=0, out and flags SHALL hold stable and no transaction SHALL be dropped or duplicated.
REQ-020 ADD: out = (a+b) mod 2^WIDTH; carry = carry-out bit WIDTH.
REQ-021 SUB: out = (a-b) mod 2^WIDTH; carry = 1 iff a < b unsigned (borrow).
REQ-022 AND/OR: out = a&b / a|b; carry = 0; overflow = 0.
REQ-023 overflow SHALL be two's-complement signed overflow for ADD/SUB.
REQ-024 zero = (out == 0); sign = out[WIDTH-1]; parity = XOR-reduction of out.
REQ-025 Simultaneous output handshake and S1->S2 transfer SHALL replace S2 contents in the same edge with no bubble.
REQ-026 Outputs SHALL not depend combinationally on a, b or select.

Reset
REQ-027 On rst=1, S1_valid and S2_valid SHALL clear immediately; in-flight operations SHALL be discarded.
REQ-028 During and after reset: out_valid=0, out=0, all flags=0, op_count=0; in_ready=1 from the first cycle after rst deasserts.
REQ-029 rst asserted mid-stall SHALL drop the held result; no result SHALL emerge afterwards for pre-reset operands.

Configuration
REQ-030 Macro ALU_PIPE_OPCOUNT_EN SHALL gate the op_count feature.
REQ-031 Without it: port op_count and its register SHALL not exist; all other behaviour unchanged.
REQ-032 With it: op_count SHALL increment by 1 on each output handshake, saturate at 16'hFFFF, and reset to 0.

Structure
REQ-033 Shared package alu_pkg SHALL hold the opcode enum (ADD, SUB, AND, OR), the default WIDTH constant and a packed flags struct.
REQ-034 A combinational sub-module alu_core (a, b, select -> out, flags) SHALL be instantiated between S1 and S2.

Verification
REQ-035 ADD a=7 b=1, out_ready=1 -> two cycles later out=8, carry=0, overflow=1, sign=1, zero=0, parity=1.
REQ-036 SUB a=3 b=5 -> out=14, carry=1, overflow=0, sign=1, parity=1; ADD a=15 b=1 -> out=0, carry=1, zero=1, overflow=0.
REQ-037 AND a=12 b=10 -> out=8; OR a=12 b=10 -> out=14; carry=0, overflow=0 for both.
REQ-038 Back-to-back 8 operations with out_ready=0 for cycles 3-6 -> in_ready=0 after both stages fill, all 8 results delivered in order, none lost or repeated.
REQ-039 rst pulsed while S1 and S2 both valid -> out_valid=0 and all outputs 0 at once; no stale result after release.
REQ-040 With ALU_PIPE_OPCOUNT_EN: 5 output handshakes -> op_count=5; forced at 16'hFFFE then 3 handshakes -> 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode enum, default width and flag struct shared by the ALU pipeline
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } opcode_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic parity;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: result plus zero/carry/sign/parity/overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output flags_t           flags
);

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  always_comb begin
    ext   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (opcode_e'(select))
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // the extended difference wraps negative exactly when a < b, giving the borrow
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      default: res = '0;
    endcase
  end

  assign out            = res;
  assign flags.zero     = (res == '0);
  assign flags.carry    = carry;
  assign flags.sign     = res[WIDTH-1];
  assign flags.parity   = ^res;
  assign flags.overflow = ovf;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline (operand stage, result stage)
// ALU_PIPE_OPCOUNT_EN adds a saturating op_count of completed output handshakes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow
`ifdef ALU_PIPE_OPCOUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_sel;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_out;
  flags_t           s2_flags;

  logic [WIDTH-1:0] core_out;
  flags_t           core_flags;

  logic s2_free;
  logic accept;
  logic advance;

  // S2 can take a new result when empty or when its current one leaves this edge
  assign s2_free  = !s2_valid || out_ready;
  assign advance  = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_sel   <= select;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .select (s1_sel),
    .out    (core_out),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_flags <= '0;
    end else begin
      if (advance) begin
        s2_valid <= 1'b1;
        s2_out   <= core_out;
        s2_flags <= core_flags;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out       = s2_out;
  assign zero      = s2_flags.zero;
  assign carry     = s2_flags.carry;
  assign sign      = s2_flags.sign;
  assign parity    = s2_flags.parity;
  assign overflow  = s2_flags.overflow;

`ifdef ALU_PIPE_OPCOUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (s2_valid && out_ready && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
